// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and transmitter signals around uart_tx_arbiter.
// master: the arbiter's view; slave: the requesters/transmitter side.
interface uart_tx_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       par0;
    logic       par1;
    logic       ack0;
    logic       ack1;
    logic [7:0] tx_data;
    logic       tx_parity;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       grant;
    logic       timeout_err;

    modport master (
        input  req0, req1, data0, data1, par0, par1, tx_done,
        output ack0, ack1, tx_data, tx_parity, tx_start, busy, grant, timeout_err
    );

    modport slave (
        output req0, req1, data0, data1, par0, par1, tx_done,
        input  ack0, ack1, tx_data, tx_parity, tx_start, busy, grant, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer in front of the UART transmitter.
// Grants one of two byte requesters, pulses tx_start once, holds the grant
// until tx_done, then acks the owner.
// Optional: define UART_ARB_TIMEOUT_EN to force completion (with timeout_err)
// when the transmitter never reports tx_done.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 8192,
    parameter int unsigned TO_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StAck   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] tx_data_q;
    logic       tx_parity_q;
    logic       grant_q;
    logic       last_grant_q;
    logic       take;
    logic       sel;
    logic       timeout_hit;
    logic       timeout_q;

    // Pick a requester: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        take = 1'b0;
        sel  = 1'b0;
        if (bus.req0 && bus.req1) begin
            take = 1'b1;
            sel  = ~last_grant_q;
        end else if (bus.req0) begin
            take = 1'b1;
            sel  = 1'b0;
        end else if (bus.req1) begin
            take = 1'b1;
            sel  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; tx_done outside WAIT is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (take) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (bus.tx_done || timeout_hit) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latch the winner's byte on grant; remember the owner once its frame is acked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_q    <= 8'h00;
            tx_parity_q  <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            if (state_q == StIdle && take) begin
                tx_data_q   <= sel ? bus.data1 : bus.data0;
                tx_parity_q <= sel ? bus.par1 : bus.par0;
                grant_q     <= sel;
            end
            if (state_q == StAck) begin
                last_grant_q <= grant_q;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Hit one WAIT cycle early so the forced ACK lands as the count reaches the limit.
    localparam logic [TO_W-1:0] ToHit = TO_W'(TIMEOUT_CYCLES - 2);

    logic [TO_W-1:0] to_cnt_q;

    // WAIT-cycle counter, cleared outside WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q == StWait) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == StWait) && (to_cnt_q == ToHit);

    // Remember that the coming ACK is forced; a real tx_done on that edge wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit && !bus.tx_done;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign timeout_q   = 1'b0;
    assign unused_cfg  = (TIMEOUT_CYCLES < 32'd2) || (TO_W == 32'd0);
`endif

    // Moore outputs decoded from registered state only.
    always_comb begin
        bus.tx_start    = (state_q == StStart);
        bus.ack0        = (state_q == StAck) && !grant_q;
        bus.ack1        = (state_q == StAck) && grant_q;
        bus.timeout_err = (state_q == StAck) && timeout_q;
        bus.busy        = (state_q != StIdle);
        bus.grant       = grant_q;
        bus.tx_data     = tx_data_q;
        bus.tx_parity   = tx_parity_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized round-robin traffic
// checked against a rule-level arbitration model.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_last;   // model: requester served last

`ifdef UART_ARB_TIMEOUT_EN
    localparam int LongDwell = 12;
`else
    localparam int LongDwell = 99;
`endif

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .TIMEOUT_CYCLES(16),
        .TO_W          (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-robin rule: a lone request wins; on a tie, the one not served last wins.
    function automatic logic exp_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        bus.req0    = 1'b0;
        bus.req1    = 1'b0;
        bus.data0   = 8'h00;
        bus.data1   = 8'h00;
        bus.par0    = 1'b0;
        bus.par1    = 1'b0;
        bus.tx_done = 1'b0;
        repeat (2) tick();
        reset  = 1'b0;
        m_last = 1'b1;
    endtask

    // Called in the START cycle. Returns tx_start one cycle later, the ack/timeout
    // seen after tx_done, and {busy, ack0, ack1, tx_start} one cycle after that.
    task automatic finish_frame(input int dwell, input logic drop, output logic st_after,
                                output logic a0, output logic a1, output logic te,
                                output logic [3:0] flags_after);
        tick();
        st_after = bus.tx_start;
        repeat (dwell) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        a0 = bus.ack0;
        a1 = bus.ack1;
        te = bus.timeout_err;
        if (drop) begin
            if (a0) bus.req0 = 1'b0;
            if (a1) bus.req1 = 1'b0;
        end
        tick();
        flags_after = {bus.busy, bus.ack0, bus.ack1, bus.tx_start};
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (bus.tx_data !== 8'h00 || bus.tx_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got data=%h par=%b want 00/0", bus.tx_data, bus.tx_parity);
        end
        n_tests++;
        if ({bus.tx_start, bus.ack0, bus.ack1, bus.busy, bus.timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got start/ack0/ack1/busy/to=%b want 00000",
                     {bus.tx_start, bus.ack0, bus.ack1, bus.busy, bus.timeout_err});
        end
        n_tests++;
        if (bus.grant !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_grant got %b want 0", bus.grant);
        end
    endtask

    task automatic test_single();
        logic st, a0, a1, te;
        logic [3:0] fl;
        apply_reset();
        bus.req0  = 1'b1;
        bus.data0 = 8'hA5;
        bus.par0  = 1'b1;
        tick();
        n_tests++;
        if ({bus.tx_start, bus.busy, bus.grant, bus.tx_parity} !== 4'b1101 ||
            bus.tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_start got start=%b busy=%b grant=%b par=%b data=%h want 1/1/0/1/a5",
                     bus.tx_start, bus.busy, bus.grant, bus.tx_parity, bus.tx_data);
        end
        finish_frame(LongDwell, 1'b1, st, a0, a1, te, fl);
        n_tests++;
        if (st !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_width got tx_start=%b in 2nd cycle want 0", st);
        end
        n_tests++;
        if ({a0, a1, te} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_ack got ack0/ack1/to=%b want 100", {a0, a1, te});
        end
        n_tests++;
        if (fl !== 4'b0) begin
            n_fail++;
            $display("FAIL single_after got busy/ack0/ack1/start=%b want 0000", fl);
        end
        m_last = 1'b0;
    endtask

    task automatic test_alternation();
        logic [7:0] exp_seq [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        logic st, a0, a1, te, w;
        logic [3:0] fl;
        apply_reset();
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                bus.req0 = 1'b1;
                bus.req1 = 1'b1;
            end
            w = (k % 2 == 1);
            tick();
            n_tests++;
            if (bus.tx_start !== 1'b1 || bus.tx_data !== exp_seq[k] || bus.grant !== w) begin
                n_fail++;
                $display("FAIL alt_order k=%0d got start=%b data=%h grant=%b want 1/%h/%b",
                         k, bus.tx_start, bus.tx_data, bus.grant, exp_seq[k], w);
            end
            finish_frame(3, 1'b1, st, a0, a1, te, fl);
            n_tests++;
            if ({a0, a1} !== (w ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL alt_ack k=%0d got ack0/ack1=%b want %b", k, {a0, a1},
                         (w ? 2'b01 : 2'b10));
            end
        end
        m_last = 1'b1;
    endtask

    task automatic test_no_starve();
        logic st, a0, a1, te;
        logic [3:0] fl;
        apply_reset();
        bus.req1  = 1'b1;
        bus.data1 = 8'h33;
        tick();
        n_tests++;
        if (bus.tx_start !== 1'b1 || bus.grant !== 1'b1 || bus.tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL starve_first got start=%b grant=%b data=%h want 1/1/33",
                     bus.tx_start, bus.grant, bus.tx_data);
        end
        tick();
        tick();
        bus.req0  = 1'b1;
        bus.data0 = 8'h44;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_tests++;
        if ({bus.ack0, bus.ack1} !== 2'b01) begin
            n_fail++;
            $display("FAIL starve_ack1 got ack0/ack1=%b want 01", {bus.ack0, bus.ack1});
        end
        tick();
        tick();
        n_tests++;
        if (bus.tx_start !== 1'b1 || bus.grant !== 1'b0 || bus.tx_data !== 8'h44) begin
            n_fail++;
            $display("FAIL starve_req0_next got start=%b grant=%b data=%h want 1/0/44",
                     bus.tx_start, bus.grant, bus.tx_data);
        end
        finish_frame(2, 1'b1, st, a0, a1, te, fl);
        tick();
        n_tests++;
        if (bus.tx_start !== 1'b1 || bus.grant !== 1'b1 || bus.tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL starve_req1_again got start=%b grant=%b data=%h want 1/1/33",
                     bus.tx_start, bus.grant, bus.tx_data);
        end
        finish_frame(2, 1'b1, st, a0, a1, te, fl);
        m_last = 1'b1;
    endtask

    task automatic test_done_ignored();
        apply_reset();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_tests++;
        if ({bus.busy, bus.ack0, bus.ack1, bus.tx_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL done_in_idle got busy/ack0/ack1/start=%b want 0000",
                     {bus.busy, bus.ack0, bus.ack1, bus.tx_start});
        end
        bus.req0  = 1'b1;
        bus.data0 = 8'h5A;
        tick();
        bus.tx_done = 1'b1;   // sampled on the START->WAIT edge
        tick();
        bus.tx_done = 1'b0;
        tick();
        n_tests++;
        if ({bus.busy, bus.ack0, bus.ack1} !== 3'b100) begin
            n_fail++;
            $display("FAIL done_in_start got busy/ack0/ack1=%b want 100",
                     {bus.busy, bus.ack0, bus.ack1});
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_tests++;
        if ({bus.ack0, bus.ack1} !== 2'b10) begin
            n_fail++;
            $display("FAIL done_in_wait got ack0/ack1=%b want 10", {bus.ack0, bus.ack1});
        end
        bus.req0 = 1'b0;
        tick();
        m_last = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic bad;
        logic st, a0, a1, te;
        logic [3:0] fl;
        apply_reset();
        bus.req1  = 1'b1;
        bus.data1 = 8'hC3;
        bus.par1  = 1'b1;
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.tx_data, bus.tx_parity, bus.tx_start, bus.ack0, bus.ack1, bus.busy, bus.grant,
             bus.timeout_err} !== 15'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async got data=%h par=%b start=%b ack=%b%b busy=%b grant=%b to=%b want all 0",
                     bus.tx_data, bus.tx_parity, bus.tx_start, bus.ack0, bus.ack1, bus.busy,
                     bus.grant, bus.timeout_err);
        end
        bus.req1 = 1'b0;
        tick();
        reset  = 1'b0;
        m_last = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ack0 || bus.ack1 || bus.busy) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_noack got spurious ack/busy=%b want 0", bad);
        end
        bus.req0  = 1'b1;
        bus.data0 = 8'h77;
        tick();
        n_tests++;
        if (bus.tx_start !== 1'b1 || bus.grant !== 1'b0 || bus.tx_data !== 8'h77) begin
            n_fail++;
            $display("FAIL reset_mid_regrant got start=%b grant=%b data=%h want 1/0/77",
                     bus.tx_start, bus.grant, bus.tx_data);
        end
        finish_frame(4, 1'b1, st, a0, a1, te, fl);
        n_tests++;
        if ({a0, a1} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_ack got ack0/ack1=%b want 10", {a0, a1});
        end
        m_last = 1'b0;
    endtask

    task automatic test_timeout();
`ifdef UART_ARB_TIMEOUT_EN
        int n;
        logic te;
        apply_reset();
        bus.req0 = 1'b1;
        tick();
        n  = 0;
        te = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus.ack0) begin
                te = bus.timeout_err;
                break;
            end
        end
        n_tests++;
        if (n !== 16 || te !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_forced got ack after %0d cycles to=%b want 16/1", n, te);
        end
        bus.req0 = 1'b0;
        tick();
        bus.req1 = 1'b1;
        tick();
        repeat (15) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_tests++;
        if ({bus.ack1, bus.timeout_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_race got ack1/to=%b want 10", {bus.ack1, bus.timeout_err});
        end
        bus.req1 = 1'b0;
        tick();
        m_last = 1'b1;
`else
        logic bad;
        apply_reset();
        bus.req0 = 1'b1;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ack0 || bus.ack1 || bus.timeout_err || !bus.busy) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_hold got early completion=%b want 0", bad);
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        n_tests++;
        if ({bus.ack0, bus.timeout_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL no_timeout_ack got ack0/to=%b want 10", {bus.ack0, bus.timeout_err});
        end
        bus.req0 = 1'b0;
        tick();
        m_last = 1'b0;
`endif
    endtask

    task automatic test_random();
        logic st, a0, a1, te, w, exp_p;
        logic [7:0] exp_d;
        logic [3:0] fl;
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            if (!bus.req0 && $urandom_range(0, 1) == 1) begin
                bus.req0  = 1'b1;
                bus.data0 = 8'($urandom);
                bus.par0  = 1'($urandom);
            end
            if (!bus.req1 && $urandom_range(0, 1) == 1) begin
                bus.req1  = 1'b1;
                bus.data1 = 8'($urandom);
                bus.par1  = 1'($urandom);
            end
            if (!bus.req0 && !bus.req1) begin
                bus.req0  = 1'b1;
                bus.data0 = 8'($urandom);
                bus.par0  = 1'($urandom);
            end
            w     = exp_pick(bus.req0, bus.req1, m_last);
            exp_d = w ? bus.data1 : bus.data0;
            exp_p = w ? bus.par1 : bus.par0;
            tick();
            n_tests++;
            if (bus.tx_start !== 1'b1 || bus.grant !== w || bus.tx_data !== exp_d ||
                bus.tx_parity !== exp_p) begin
                n_fail++;
                $display("FAIL rand_grant it=%0d got start=%b grant=%b data=%h par=%b want 1/%b/%h/%b",
                         it, bus.tx_start, bus.grant, bus.tx_data, bus.tx_parity, w, exp_d, exp_p);
            end
            finish_frame(int'($urandom_range(0, 12)), ($urandom_range(0, 3) != 0),
                         st, a0, a1, te, fl);
            n_tests++;
            if ({st, a0, a1, te} !== (w ? 4'b0010 : 4'b0100)) begin
                n_fail++;
                $display("FAIL rand_ack it=%0d got start2/ack0/ack1/to=%b want %b",
                         it, {st, a0, a1, te}, (w ? 4'b0010 : 4'b0100));
            end
            n_tests++;
            if (fl !== 4'b0) begin
                n_fail++;
                $display("FAIL rand_idle it=%0d got busy/ack0/ack1/start=%b want 0000", it, fl);
            end
            m_last = w;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternation();
        test_no_starve();
        test_done_ignored();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-requester arbiter and sequencer for the UART transmit path. It accepts byte-send requests from two independent sources, such as the CPU register path and an Rx-echo/debug path. It grants them round-robin, drives the transmitter's data, parity and start inputs, and holds the grant until the transmitter reports frame completion. It sits between the requesters and the Tx register encoder/transmitter, and is the only block allowed to pulse the transmitter's start input.

## Interface
- TIMEOUT_CYCLES, 16'd8192, max cycles in WAIT before forced completion (only used with the timeout feature); must be ≥ 2
- TO_W, 16, width of the timeout counter; TIMEOUT_CYCLES must fit in it
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared on assertion
- req0 / req1  in  1  level request; held high with data stable until the matching ack
- data0 / data1  in  8  byte to send
- par0 / par1  in  1  parity-enable for that byte
- ack0 / ack1  out  1  one-cycle completion pulse to the granted requester
- tx_data  out  8  byte to transmitter; stable from grant until ACK
- tx_parity  out  1  parity select to transmitter; stable with tx_data
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_done  in  1  one-cycle frame-complete pulse from transmitter
- busy  out  1  high whenever state ≠ IDLE
- grant  out  1  index of current/last owner (0 or 1)
- timeout_err  out  1  one-cycle pulse coincident with ack on forced completion

## Operation
- States: IDLE, START, WAIT, ACK (binary encoded, registered).
- IDLE:
  - No request: stay.
  - Exactly one req high: grant it.
  - Both high: grant the requester ≠ last_grant.
  - On grant: latch dataN/parN into tx_data/tx_parity, set grant, go to START.
- START: tx_start = 1 for exactly this cycle; next state WAIT unconditionally.
- WAIT: tx_done high at an edge moves to ACK. tx_done in any other state is ignored and dropped.
- ACK:
  - ack[grant] = 1 for this cycle.
  - last_grant ← grant.
  - Next state IDLE.
- Requester rule: req must be low in the cycle after its ack, unless a new byte is intended. A req still high then is treated as a new request.
- tx_start, ackN and timeout_err are decoded from the state register (glitch-free Moore outputs). They are never high outside their state.
- tx_data/tx_parity change only on an IDLE→START transition.
- Reset values:
  - state = IDLE; tx_data = 8'h00; tx_parity = 0; tx_start = 0.
  - ack0 = ack1 = 0; busy = 0; grant = 0; timeout_err = 0.
  - last_grant = 1, so requester 0 wins the first simultaneous request.
- Reset mid-frame: return to IDLE immediately. No ack is issued for the aborted byte, and the requester must re-request.

## Timing
- Request latency: req sampled high in IDLE at edge E0 → tx_start high in cycle E0..E1.
- Completion latency: tx_done sampled at edge En → ack high in cycle En..En+1 → IDLE at En+1.
- Back-to-back: minimum spacing between tx_start pulses is 3 cycles plus the transmitter frame time. The other requester is never starved by more than one frame.
- tx_done coinciding with the START cycle is ignored, because the transmitter cannot complete in one cycle.
- A req that drops before it is granted is not latched and is not acked.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES−1 without tx_done, go to ACK with timeout_err = 1 during that ACK cycle.
  - tx_done on the same edge takes priority (normal ACK, timeout_err = 0).
- UART_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts until tx_done; timeout_err is tied to 0. The port is kept, so the interface does not change.

## Test plan
- Reset, then req0=1, data0=8'hA5, par0=1: tx_start pulses for 1 cycle, one cycle after sampling; tx_data=8'hA5, tx_parity=1, grant=0. Drive tx_done 100 cycles later: ack0 pulses 1 cycle, busy falls next cycle.
- req0 and req1 both high from reset with data 8'h11/8'h22, each dropped after its ack: frames go out 8'h11 then 8'h22. Re-raise both: order is 8'h11, 8'h22 again (strict alternation).
- req1 held continuously while req0 pulses once mid-frame: after req1's ack, req0 is granted next, before req1's second byte.
- tx_done pulsed during IDLE and during START: no state change and no ack; the frame completes only on a later tx_done in WAIT.
- Assert reset during WAIT: all outputs return to reset values asynchronously, no ack is issued, and the next req0 is granted normally.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, never drive tx_done: ack and timeout_err pulse together 16 cycles after the START cycle. A tx_done on the final count edge gives a normal ack with timeout_err=0.
